// File: rtl/video_line_fetcher_if.sv
// Bundle of the line-control, memory read port and byte pixelstream signals
// of the video line fetcher; master is the fetcher, slave is its surroundings.
interface video_line_fetcher_if #(
    parameter int ADDR_W = 21,
    parameter int LEN_W  = 9
);
    logic              line_start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  line_words;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic              pix_write;
    logic [7:0]        pix_data;
    logic              pix_strobe;
    logic              busy;
    logic              line_done;

    modport master (
        input  line_start, start_addr, line_words, mem_ack, mem_rdata, pix_strobe,
        output mem_req, mem_addr, pix_write, pix_data, busy, line_done
    );

    modport slave (
        output line_start, start_addr, line_words, mem_ack, mem_rdata, pix_strobe,
        input  mem_req, mem_addr, pix_write, pix_data, busy, line_done
    );
endinterface

// File: rtl/video_line_fetcher.sv
// Fetches one line of 16-bit words from video RAM (single outstanding read)
// into a small FIFO and streams it out as bytes, high byte first.
module video_line_fetcher #(
    parameter int ADDR_W     = 21,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 9
) (
    input logic                  clk,
    input logic                  reset,
    video_line_fetcher_if.master bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [LEN_W-1:0]  line_words_q, line_words_d;
    logic [LEN_W-1:0]  words_req_q, words_req_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sel_hi_q, sel_hi_d;
    logic              line_done_q, line_done_d;
    logic [15:0]       fifo_q [FIFO_DEPTH];

    logic [15:0] head;
    logic        pix_write;
    logic        ack;
    logic        strobe;
    logic        pop;
    logic        last_pop;
    logic        push;
    logic        flush;
    logic        outstanding;
    logic        issue;

    assign head      = fifo_q[rd_ptr_q];
    assign pix_write = (count_q != '0);
    assign ack       = bus.mem_ack && mem_req_q;
    assign strobe    = pix_write && bus.pix_strobe;
    // A new line discards the FIFO, so it overrides any pop in the same cycle.
    assign pop       = strobe && !sel_hi_q && !bus.line_start;
    assign last_pop  = pop && (count_q == CNT_W'(1));
    // Request still in flight after this edge; an abort must then wait in FLUSH.
    assign outstanding = mem_req_q && !bus.mem_ack;
    assign issue = (state_q == S_FETCH) && !mem_req_q &&
                   (words_req_q < line_words_q) &&
                   (count_q < CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.line_start) begin
            if (outstanding)                state_d = S_FLUSH;
            else if (bus.line_words == '0)  state_d = S_IDLE;
            else                            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: if (ack && (words_req_q == line_words_q)) state_d = S_DRAIN;
                S_DRAIN: if (last_pop) state_d = S_IDLE;
                S_FLUSH: if (ack) state_d = (line_words_q == '0) ? S_IDLE : S_FETCH;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        start_addr_d = start_addr_q;
        line_words_d = line_words_q;
        words_req_d  = words_req_q;
        sel_hi_d     = sel_hi_q;
        line_done_d  = 1'b0;
        push         = 1'b0;
        flush        = 1'b0;
        if (bus.line_start) begin
            start_addr_d = bus.start_addr;
            line_words_d = bus.line_words;
            sel_hi_d     = 1'b1;
            flush        = 1'b1;
            if (outstanding) begin
                words_req_d = '0;
            end else if (bus.line_words != '0) begin
                // Nothing in flight: the first read goes out right away.
                mem_req_d   = 1'b1;
                mem_addr_d  = bus.start_addr;
                words_req_d = LEN_W'(1);
            end else begin
                mem_req_d   = 1'b0;
                words_req_d = '0;
                line_done_d = 1'b1;
            end
        end else begin
            if (strobe) sel_hi_d = !sel_hi_q;
            if (ack) begin
                mem_req_d = 1'b0;
                if (state_q == S_FLUSH) begin
                    mem_addr_d  = start_addr_q;
                    words_req_d = '0;
                    line_done_d = (line_words_q == '0);
                end else begin
                    push       = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
            end else if (issue) begin
                mem_req_d   = 1'b1;
                words_req_d = words_req_q + LEN_W'(1);
            end
            if ((state_q == S_DRAIN) && last_pop) line_done_d = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_q    <= 1'b0;
            line_words_q <= '0;
            words_req_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sel_hi_q     <= 1'b1;
            line_done_q  <= 1'b0;
        end else begin
            mem_req_q    <= mem_req_d;
            line_words_q <= line_words_d;
            words_req_q  <= words_req_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sel_hi_q     <= sel_hi_d;
            line_done_q  <= line_done_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_addr_q   <= mem_addr_d;
        start_addr_q <= start_addr_d;
        if (push) fifo_q[wr_ptr_q] <= bus.mem_rdata;
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.pix_write = pix_write;
    assign bus.pix_data  = sel_hi_q ? head[15:8] : head[7:0];
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.line_done = line_done_q;

endmodule

// File: doc/video_line_fetcher.md
Name: video_line_fetcher

Overview:
- Upstream stage of the pixel decoders (delta YUV, CLUT, run-length). At each line start it fetches a line of 16-bit words from video RAM through a single-outstanding read port.
- Buffers the words in a small FIFO and emits them as a byte pixelstream (write/strobe handshake), high byte first.
- Handles prefetch, backpressure, end-of-line drain and mid-line abort.

Parameters:
- ADDR_W, 21, word-address width of the memory port.
- FIFO_DEPTH, 8, FIFO depth in 16-bit words (power of two, >=2).
- LEN_W, 9, width of the line length field in words.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- line_start  in  1  one-cycle pulse; latch start_addr/line_words and begin a line (aborts any line in progress)
- start_addr  in  ADDR_W  word address of the first word of the line
- line_words  in  LEN_W  number of words in the line (e.g. 180 = 360 bytes, 192 = 384 bytes)
- mem_req  out  1  read request, held until mem_ack
- mem_addr  out  ADDR_W  word address, stable while mem_req=1
- mem_ack  in  1  one-cycle pulse; mem_rdata valid in the same cycle
- mem_rdata  in  16  read data
- pix_write  out  1  byte available on pix_data
- pix_data  out  8  current byte
- pix_strobe  in  1  sink consumes the byte this cycle (only meaningful when pix_write=1; may be driven combinationally from pix_write)
- busy  out  1  line in progress (FETCH, DRAIN or FLUSH)
- line_done  out  1  one-cycle pulse when the last byte of a line has been consumed

Behaviour:
- Reset values: mem_req=0, pix_write=0, busy=0, line_done=0. FIFO is emptied, byte select is set to high, state is IDLE. The memory controller shares reset, so no in-flight ack survives reset.
- pix_write=1 whenever the FIFO is non-empty.
- pix_data = head[15:8] when byte select is high, head[7:0] when low.
- Consumption:
  - pix_write && pix_strobe with select high: select goes low.
  - pix_write && pix_strobe with select low: pop head, select goes high.
  - pix_strobe while pix_write=0 is ignored.
- Request issue, all registered:
  - Issue when state is FETCH, mem_req=0, words_requested < line_words, and (fifo_count + outstanding) < FIFO_DEPTH.
  - mem_req rises on the cycle after the condition holds.
  - The first request after line_start therefore appears at cycle +1, with mem_addr=start_addr.
- Acknowledge handling:
  - On mem_ack, mem_req drops in the same edge, mem_rdata is pushed to the FIFO and mem_addr increments by 1 (wraps at 2^ADDR_W).
  - A new request may rise on the following cycle.
  - At most one request is outstanding.
- Push and pop in the same cycle leave fifo_count unchanged. The full condition is excluded by the issue rule, so an overflow can never occur.
- States:
  - IDLE: line_start goes to FETCH, with line_words=0 handled as below.
  - FETCH: when words_requested reaches line_words and the last ack has arrived, go to DRAIN.
  - DRAIN: when the final low byte is consumed (FIFO empty after the pop), pulse line_done and go to IDLE.
  - FLUSH: wait for the outstanding mem_ack, discard its data, then start the pending line (go to FETCH with the latched parameters).
- line_words=0: no requests are made. line_done pulses the cycle after line_start, and the block returns to IDLE.
- line_start while busy:
  - FIFO is flushed, select set high, new start_addr/line_words latched, no line_done for the aborted line.
  - If a request is outstanding (mem_req=1), go to FLUSH: mem_req stays asserted with the old address until mem_ack, and the ack data is dropped.
  - Otherwise go straight to FETCH.
  - line_start during FLUSH overwrites the latched parameters and stays in FLUSH.
- line_start has priority over a pop or line_done in the same cycle.
- busy=1 in FETCH, DRAIN and FLUSH.

Test Plan:
- Basic line:
  - Stimulus: start_addr=0x100, line_words=4, memory returns word = addr; ack latency 2; sink strobes every cycle.
  - Required: pix_data sequence 0x01,0x00,0x01,0x01,0x01,0x02,0x01,0x03; line_done one cycle after the 8th strobe; exactly 4 requests at 0x100..0x103.
- Backpressure:
  - Stimulus: line_words=32, sink never strobes.
  - Required: exactly FIFO_DEPTH=8 requests, then mem_req stays 0. After releasing the sink, all 64 bytes arrive in order and line_done pulses once.
- Zero length:
  - Stimulus: line_start with line_words=0.
  - Required: mem_req never rises; line_done high exactly at cycle +1; busy returns to 0.
- Abort with outstanding request:
  - Stimulus: line_start at 0x200 during a pending request at 0x105 (ack 3 cycles later, data 0xDEAD).
  - Required: 0xDE/0xAD never appear on pix_data; the next request is at 0x200; no line_done for the old line.
- Ack-latency sweep:
  - Stimulus: ack latency 1..5 combined with a random strobe pattern; line_words=192.
  - Required: all 384 bytes in order, no FIFO overflow, fifo_count+outstanding <= 8 at all times.
- Mid-line reset:
  - Stimulus: reset after 10 bytes.
  - Required: next cycle pix_write=0, mem_req=0, busy=0; a fresh line_start then fetches from the new start_addr.
